aes_block_loader: RTL

//  Upstream feeder for the AES-128 encryption core. Assembles 32-bit stream words into a 128-bit key and a 128-bit block.

---
 rtl/aes_loader_pkg.sv | 32 +++
 rtl/aes_block_loader_if.sv | 31 +++
 rtl/aes_word_packer.sv | 61 ++++++
 rtl/aes_block_loader.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/aes_loader_pkg.sv
// Shared types and constants for the AES-128 block loader.
package aes_loader_pkg;

  localparam int AES_BLK_W     = 128;
  localparam int WORD_W        = 32;
  localparam int WORDS_PER_BLK = 4;
  // Word counters run 0..WORDS_PER_BLK, so they need one bit more than an index.
  localparam int CNT_W         = 3;

  typedef enum logic [1:0] {
    WT_DATA = 2'b00,
    WT_KEY  = 2'b01,
    WT_IV   = 2'b10,
    WT_RSVD = 2'b11
  } word_type_e;

  typedef enum logic [1:0] {
    FILL   = 2'b00,
    LAUNCH = 2'b01,
    BUSY   = 2'b10
  } state_e;

  // Shift one stream word into the low end of a block buffer; the first word
  // received ends up in the most-significant position.
  function automatic logic [AES_BLK_W-1:0] shift_in(
    input logic [AES_BLK_W-1:0] blk,
    input logic [WORD_W-1:0]    word
  );
    return {blk[AES_BLK_W-WORD_W-1:0], word};
  endfunction

endpackage

// File: rtl/aes_block_loader_if.sv
// Bus bundle of the AES block loader: input word stream, AES core operand and
// result signals, ciphertext output slice and the timeout pulse.
// slave  = loader view, master = environment view.
interface aes_block_loader_if;
  import aes_loader_pkg::*;

  logic                 s_valid;
  logic                 s_ready;
  logic [1:0]           s_type;
  logic [WORD_W-1:0]    s_data;
  logic                 aes_start;
  logic [AES_BLK_W-1:0] aes_in;
  logic [AES_BLK_W-1:0] aes_key;
  logic                 core_done;
  logic [AES_BLK_W-1:0] core_result;
  logic                 m_valid;
  logic                 m_ready;
  logic [AES_BLK_W-1:0] m_data;
  logic                 err_timeout;

  modport slave (
    input  s_valid, s_type, s_data, core_done, core_result, m_ready,
    output s_ready, aes_start, aes_in, aes_key, m_valid, m_data, err_timeout
  );

  modport master (
    output s_valid, s_type, s_data, core_done, core_result, m_ready,
    input  s_ready, aes_start, aes_in, aes_key, m_valid, m_data, err_timeout
  );

endinterface

// File: rtl/aes_word_packer.sv
// 4x32-bit shift-in block buffer with a 0..4 word count.
// When full, a further push either restarts the count at 1 (RESTART_ON_FULL)
// or is ignored. clr_i empties the count but leaves the buffer contents.
module aes_word_packer
  import aes_loader_pkg::*;
#(
  parameter bit RESTART_ON_FULL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 push_i,
  input  logic [WORD_W-1:0]    word_i,
  output logic [AES_BLK_W-1:0] buf_o,
  output logic [CNT_W-1:0]     cnt_o,
  output logic                 full_o
);

  logic [AES_BLK_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  assign full_o = (cnt_q == CNT_W'(WORDS_PER_BLK));

  // Next buffer/count: clear beats push, a push into a full buffer restarts.
  always_comb begin
    // NOTE: every next-state value gets a default first, so no path through
    // this block leaves a variable unassigned and no latch is inferred.
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (push_i) begin
      if (!full_o) begin
        buf_d = shift_in(buf_q, word_i);
        cnt_d = cnt_q + CNT_W'(1);
      end else if (RESTART_ON_FULL) begin
        buf_d = shift_in(buf_q, word_i);
        cnt_d = CNT_W'(1);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: the buffer is a plain flop bank, not a RAM, so it is reset along
      // with the count; that keeps the core operands at 0 out of reset.
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  assign buf_o = buf_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/aes_block_loader.sv
// AES-128 block loader: packs 32-bit stream words into key and data blocks,
// launches the core with a one-cycle start pulse, holds the operands while the
// core is busy, abandons the block after TIMEOUT_CYC busy cycles and returns
// the ciphertext on a valid/ready register slice.
// Optional CBC chaining is enabled by defining AES_LOADER_CBC_EN.
module aes_block_loader
  import aes_loader_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                rst,
  aes_block_loader_if.slave   bus_if
);

  localparam int BUSY_W = $clog2(TIMEOUT_CYC);

  word_type_e           s_type_w;
  logic                 s_ready_w;
  logic                 accept;
  logic                 key_push, data_push;
  logic [AES_BLK_W-1:0] key_buf, data_buf, block_in;
  logic [CNT_W-1:0]     key_cnt, data_cnt;
  logic                 key_full, data_full;
  logic                 slot_free, launch_ok, timeout_hit, data_clr;

  state_e               state_q;
  logic                 aes_start_q;
  logic [AES_BLK_W-1:0] aes_in_q, aes_key_q;
  logic [BUSY_W-1:0]    busy_cnt_q;
  logic                 m_valid_q;
  logic [AES_BLK_W-1:0] m_data_q;

  assign s_type_w  = word_type_e'(bus_if.s_type);
  assign accept    = bus_if.s_valid && s_ready_w;
  assign key_push  = accept && (s_type_w == WT_KEY);
  assign data_push = accept && (s_type_w == WT_DATA);

  // Words are only taken in FILL; a fifth data word stalls until the block
  // has been consumed, other word types are always taken.
  always_comb begin
    s_ready_w = 1'b0;
    if (state_q == FILL) begin
      s_ready_w = !((s_type_w == WT_DATA) && data_full);
    end
  end

  // The busy window ends on the TIMEOUT_CYC-th BUSY cycle unless the core
  // answers in that same cycle; the pulse is visible during that cycle.
  assign timeout_hit = (state_q == BUSY) && !bus_if.core_done &&
                       (busy_cnt_q == BUSY_W'(TIMEOUT_CYC - 1));
  assign data_clr    = (state_q == BUSY) && (bus_if.core_done || timeout_hit);

  aes_word_packer #(.RESTART_ON_FULL(1'b1)) u_key_packer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (1'b0),
    .push_i (key_push),
    .word_i (bus_if.s_data),
    .buf_o  (key_buf),
    .cnt_o  (key_cnt),
    .full_o (key_full)
  );

  aes_word_packer #(.RESTART_ON_FULL(1'b0)) u_data_packer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (data_clr),
    .push_i (data_push),
    .word_i (bus_if.s_data),
    .buf_o  (data_buf),
    .cnt_o  (data_cnt),
    .full_o (data_full)
  );

  // The output slot counts as free if it is empty or being drained this cycle.
  assign slot_free = !m_valid_q || bus_if.m_ready;

`ifdef AES_LOADER_CBC_EN
  logic                 iv_push;
  logic [AES_BLK_W-1:0] iv_buf;
  logic [CNT_W-1:0]     iv_cnt;
  logic                 iv_full;
  logic [AES_BLK_W-1:0] chain_q;

  assign iv_push = accept && (s_type_w == WT_IV);

  aes_word_packer #(.RESTART_ON_FULL(1'b1)) u_iv_packer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (1'b0),
    .push_i (iv_push),
    .word_i (bus_if.s_data),
    .buf_o  (iv_buf),
    .cnt_o  (iv_cnt),
    .full_o (iv_full)
  );

  // Chain value: the last ciphertext, or a freshly completed IV.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
    end else if ((state_q == BUSY) && bus_if.core_done) begin
      chain_q <= bus_if.core_result;
    end else if (iv_push && (iv_cnt == CNT_W'(WORDS_PER_BLK - 1))) begin
      chain_q <= shift_in(iv_buf, bus_if.s_data);
    end
  end

  assign block_in  = data_buf ^ chain_q;
  assign launch_ok = data_full && key_full && iv_full && slot_free;
`else
  assign block_in  = data_buf;
  assign launch_ok = data_full && key_full && slot_free;
`endif

  // Control FSM with registered outputs. Operands are captured on the edge
  // that enters LAUNCH so they are already stable while aes_start is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      aes_start_q <= 1'b0;
      aes_in_q    <= '0;
      aes_key_q   <= '0;
      busy_cnt_q  <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
    end else begin
      aes_start_q <= 1'b0;
      if (m_valid_q && bus_if.m_ready) begin
        m_valid_q <= 1'b0;
      end
      case (state_q)
        FILL: begin
          if (launch_ok) begin
            state_q     <= LAUNCH;
            aes_start_q <= 1'b1;
            aes_in_q    <= block_in;
            aes_key_q   <= key_buf;
            busy_cnt_q  <= '0;
          end
        end
        LAUNCH: begin
          state_q <= BUSY;
        end
        BUSY: begin
          if (bus_if.core_done) begin
            m_data_q  <= bus_if.core_result;
            m_valid_q <= 1'b1;
            state_q   <= FILL;
          end else if (timeout_hit) begin
            state_q <= FILL;
          end else begin
            busy_cnt_q <= busy_cnt_q + BUSY_W'(1);
          end
        end
        default: begin
          state_q <= FILL;
        end
      endcase
    end
  end

  assign bus_if.s_ready     = s_ready_w;
  assign bus_if.aes_start   = aes_start_q;
  assign bus_if.aes_in      = aes_in_q;
  assign bus_if.aes_key     = aes_key_q;
  assign bus_if.m_valid     = m_valid_q;
  assign bus_if.m_data      = m_data_q;
  assign bus_if.err_timeout = timeout_hit;

endmodule
